// File: rtl/modulo_escalonador_rolhas_if.sv
// Operator, sealer and display-side signals of the cork-transfer scheduler.
// The master drives the line controls and the slave (scheduler) drives the counts and pulses.
interface modulo_escalonador_rolhas_if;
  logic       enable;
  logic       seal;
  logic       op_req;
  logic [6:0] op_qty;
  logic [4:0] buf_prin;
  logic [6:0] buf_sec;
  logic [1:0] estado;
  logic       ro;
  logic       op_ack;
  logic       op_reject;
  logic       refill_done;

  modport master (
    output enable, seal, op_req, op_qty,
    input  buf_prin, buf_sec, estado, ro, op_ack, op_reject, refill_done
  );

  modport slave (
    input  enable, seal, op_req, op_qty,
    output buf_prin, buf_sec, estado, ro, op_ack, op_reject, refill_done
  );
endinterface

// File: rtl/modulo_escalonador_rolhas.sv
// Cork-transfer scheduler: arbitrates the single transfer path between the automatic
// refill (secondary -> principal) and operator loads into secondary, one cork per clock,
// while the sealer consumes corks from principal concurrently.
module modulo_escalonador_rolhas #(
  parameter int INIT_SEC     = 20,
  parameter int SEC_MAX      = 99,
  parameter int MIN_PRIN     = 5,
  parameter int TRANSFER_QTY = 20
) (
  input logic clk,
  input logic clr,
  modulo_escalonador_rolhas_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REFILL = 2'b01,
    LOAD   = 2'b10
  } state_t;

  localparam logic [6:0] INIT_SEC_V = 7'(INIT_SEC);
  localparam logic [6:0] SEC_MAX_V  = 7'(SEC_MAX);
  localparam logic [4:0] MIN_PRIN_V = 5'(MIN_PRIN);
  localparam logic [6:0] XFER_V     = 7'(TRANSFER_QTY);

  state_t     state;
  state_t     state_next;
  logic [6:0] step;
  logic [4:0] buf_prin_q;
  logic [4:0] prin_next;
  logic [6:0] buf_sec_q;
  logic       op_req_q;
  logic       pending;
  logic [6:0] qty_reg;
  logic       ack_q;
  logic       reject_q;
  logic       done_q;

  logic       op_rise;
  logic       prin_low;
  logic       sec_enough;
  logic [7:0] load_sum;
  logic       load_over;
  logic       step_last;

  logic       start_refill;
  logic       start_load;
  logic       idle_ack;
  logic       idle_reject;
  logic       refill_step;
  logic       load_step;

  assign op_rise    = bus.op_req & ~op_req_q;
  assign prin_low   = buf_prin_q < MIN_PRIN_V;
  assign sec_enough = buf_sec_q >= XFER_V;
  assign load_sum   = {1'b0, buf_sec_q} + {1'b0, qty_reg};
  assign load_over  = load_sum > {1'b0, SEC_MAX_V};
  assign step_last  = step == 7'd1;

  // State register; a clear discards any in-flight transfer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state: refill beats the operator; steps only advance while enabled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_refill)    state_next = REFILL;
        else if (start_load) state_next = LOAD;
      end
      REFILL: if (refill_step && step_last) state_next = IDLE;
      LOAD:   if (load_step && step_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode: which transfer action the current state takes this cycle.
  always_comb begin
    start_refill = 1'b0;
    start_load   = 1'b0;
    idle_ack     = 1'b0;
    idle_reject  = 1'b0;
    refill_step  = 1'b0;
    load_step    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          if (prin_low && sec_enough) start_refill = 1'b1;
          else if (pending) begin
            if (qty_reg == 7'd0) idle_ack    = 1'b1;
            else if (load_over)  idle_reject = 1'b1;
            else                 start_load  = 1'b1;
          end
        end
      end
      REFILL:  refill_step = bus.enable;
      LOAD:    load_step   = bus.enable;
      default: ;
    endcase
  end

  // Principal count: refill adds one, a seal removes one unless already empty.
  always_comb begin
    prin_next = buf_prin_q;
    if (refill_step) prin_next = prin_next + 5'd1;
    if (bus.seal && buf_prin_q != 5'd0) prin_next = prin_next - 5'd1;
  end

  // Buffers, step counter, request capture and the one-cycle status pulses.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step       <= 7'd0;
      buf_prin_q <= 5'd0;
      buf_sec_q  <= INIT_SEC_V;
      op_req_q   <= 1'b0;
      pending    <= 1'b0;
      qty_reg    <= 7'd0;
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      op_req_q   <= bus.op_req;
      buf_prin_q <= prin_next;
      ack_q      <= idle_ack | (load_step & step_last);
      reject_q   <= idle_reject | (op_rise & pending);
      done_q     <= refill_step & step_last;

      if (idle_ack || idle_reject || start_load) pending <= 1'b0;
      else if (op_rise)                          pending <= 1'b1;

      if (op_rise && !pending) qty_reg <= bus.op_qty;

      if (start_refill)                  step <= XFER_V;
      else if (start_load)               step <= qty_reg;
      else if (refill_step || load_step) step <= step - 7'd1;

      if (refill_step)    buf_sec_q <= buf_sec_q - 7'd1;
      else if (load_step) buf_sec_q <= buf_sec_q + 7'd1;
    end
  end

  assign bus.buf_prin    = buf_prin_q;
  assign bus.buf_sec     = buf_sec_q;
  assign bus.estado      = state;
  assign bus.ro          = buf_prin_q == 5'd0;
  assign bus.op_ack      = ack_q;
  assign bus.op_reject   = reject_q;
  assign bus.refill_done = done_q;

  a_sec_max: assert property (@(posedge clk) disable iff (!clr) buf_sec_q <= SEC_MAX_V);
  a_sec_underflow: assert property (@(posedge clk) disable iff (!clr) !(refill_step && buf_sec_q == 7'd0));
  a_sec_overflow: assert property (@(posedge clk) disable iff (!clr) !(load_step && buf_sec_q >= SEC_MAX_V));
  a_prin_max: assert property (@(posedge clk) disable iff (!clr) !(refill_step && buf_prin_q == 5'd31));

endmodule

// File: tb/tb_modulo_escalonador_rolhas.sv
// Testbench for the cork-transfer scheduler: scenario tasks with inline checks and a
// pulse scoreboard ({kind, buf_prin, buf_sec}; kind 1 ack, 2 reject, 3 refill_done).
module tb_modulo_escalonador_rolhas;
  logic clk = 1'b0;
  logic clr;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];

  modulo_escalonador_rolhas_if bus();

  modulo_escalonador_rolhas dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit after the edge and record any pulses.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus.op_ack)      obs_q.push_back({2'd1, bus.buf_prin, bus.buf_sec});
    if (bus.op_reject)   obs_q.push_back({2'd2, bus.buf_prin, bus.buf_sec});
    if (bus.refill_done) obs_q.push_back({2'd3, bus.buf_prin, bus.buf_sec});
  endtask

  task automatic test_reset();
    logic [13:0] e, o;
    clr = 1'b1;
    bus.enable = 1'b0; bus.seal = 1'b0; bus.op_req = 1'b0; bus.op_qty = 7'd0;
    #3 clr = 1'b0;
    cycle(); cycle();
    tests_run++;
    if (bus.buf_prin !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_prin: got %0d want 0", bus.buf_prin); end
    tests_run++;
    if (bus.buf_sec !== 7'd20) begin tests_failed++; $display("[TB] FAIL reset_sec: got %0d want 20", bus.buf_sec); end
    tests_run++;
    if (bus.estado !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_estado: got %b want 00", bus.estado); end
    tests_run++;
    if (bus.ro !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ro: got %b want 1", bus.ro); end
    tests_run++;
    if ({bus.op_ack, bus.op_reject, bus.refill_done} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL reset_pulses: got %b want 000", {bus.op_ack, bus.op_reject, bus.refill_done});
    end
    clr = 1'b1;
    bus.enable = 1'b1;
    exp_q.push_back({2'd3, 5'd20, 7'd0});
    cycle();
    tests_run++;
    if (bus.estado !== 2'b01 || bus.ro !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL boot_refill_start: got estado %b ro %b want 01 1", bus.estado, bus.ro);
    end
    cycle();
    tests_run++;
    if (bus.buf_prin !== 5'd1 || bus.buf_sec !== 7'd19 || bus.ro !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL boot_first_step: got prin %0d sec %0d ro %b want 1 19 0", bus.buf_prin, bus.buf_sec, bus.ro);
    end
    repeat (19) cycle();
    tests_run++;
    if (bus.estado !== 2'b00 || bus.buf_prin !== 5'd20 || bus.buf_sec !== 7'd0) begin
      tests_failed++; $display("[TB] FAIL boot_refill_end: got estado %b prin %0d sec %0d want 00 20 0", bus.estado, bus.buf_prin, bus.buf_sec);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 14'h3FFF;
      tests_run++;
      if (o !== e) begin tests_failed++; $display("[TB] FAIL reset_sb: got k%0d p%0d s%0d want k%0d p%0d s%0d", o[13:12], o[11:7], o[6:0], e[13:12], e[11:7], e[6:0]); end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL reset_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_refill_priority();
    logic [13:0] e, o;
    bus.op_qty = 7'd30; bus.op_req = 1'b1;
    exp_q.push_back({2'd1, 5'd20, 7'd30});
    cycle();
    bus.op_req = 1'b0;
    repeat (31) cycle();
    bus.enable = 1'b0; bus.seal = 1'b1;
    repeat (17) cycle();
    bus.seal = 1'b0;
    tests_run++;
    if (bus.buf_prin !== 5'd3 || bus.buf_sec !== 7'd30) begin
      tests_failed++; $display("[TB] FAIL prio_setup: got prin %0d sec %0d want 3 30", bus.buf_prin, bus.buf_sec);
    end
    bus.op_qty = 7'd10; bus.op_req = 1'b1;
    cycle();
    bus.op_req = 1'b0; bus.enable = 1'b1;
    exp_q.push_back({2'd3, 5'd23, 7'd10});
    exp_q.push_back({2'd1, 5'd23, 7'd20});
    cycle();
    tests_run++;
    if (bus.estado !== 2'b01) begin tests_failed++; $display("[TB] FAIL prio_refill_first: got estado %b want 01", bus.estado); end
    repeat (31) cycle();
    tests_run++;
    if (bus.estado !== 2'b00 || bus.buf_sec !== 7'd20 || bus.buf_prin !== 5'd23) begin
      tests_failed++; $display("[TB] FAIL prio_end: got estado %b prin %0d sec %0d want 00 23 20", bus.estado, bus.buf_prin, bus.buf_sec);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 14'h3FFF;
      tests_run++;
      if (o !== e) begin tests_failed++; $display("[TB] FAIL prio_sb: got k%0d p%0d s%0d want k%0d p%0d s%0d", o[13:12], o[11:7], o[6:0], e[13:12], e[11:7], e[6:0]); end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL prio_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_capacity();
    logic [13:0] e, o;
    bus.op_qty = 7'd75; bus.op_req = 1'b1;
    exp_q.push_back({2'd1, 5'd23, 7'd95});
    cycle();
    bus.op_req = 1'b0;
    repeat (76) cycle();
    bus.op_qty = 7'd5; bus.op_req = 1'b1;
    exp_q.push_back({2'd2, 5'd23, 7'd95});
    cycle();
    bus.op_req = 1'b0;
    cycle();
    tests_run++;
    if (bus.estado !== 2'b00 || bus.buf_sec !== 7'd95) begin
      tests_failed++; $display("[TB] FAIL cap_reject: got estado %b sec %0d want 00 95", bus.estado, bus.buf_sec);
    end
    cycle();
    tests_run++;
    if (bus.estado !== 2'b00) begin tests_failed++; $display("[TB] FAIL cap_no_load: got estado %b want 00", bus.estado); end
    bus.op_qty = 7'd4; bus.op_req = 1'b1;
    exp_q.push_back({2'd1, 5'd23, 7'd99});
    cycle();
    bus.op_req = 1'b0;
    repeat (5) cycle();
    tests_run++;
    if (bus.buf_sec !== 7'd99) begin tests_failed++; $display("[TB] FAIL cap_fill: got sec %0d want 99", bus.buf_sec); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 14'h3FFF;
      tests_run++;
      if (o !== e) begin tests_failed++; $display("[TB] FAIL cap_sb: got k%0d p%0d s%0d want k%0d p%0d s%0d", o[13:12], o[11:7], o[6:0], e[13:12], e[11:7], e[6:0]); end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL cap_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_seal();
    logic [13:0] e, o;
    bus.enable = 1'b0; bus.seal = 1'b1;
    repeat (19) cycle();
    bus.seal = 1'b0; bus.enable = 1'b1;
    exp_q.push_back({2'd3, 5'd4, 7'd79});
    exp_q.push_back({2'd3, 5'd24, 7'd59});
    cycle();
    tests_run++;
    if (bus.estado !== 2'b01 || bus.buf_prin !== 5'd4) begin
      tests_failed++; $display("[TB] FAIL seal_start: got estado %b prin %0d want 01 4", bus.estado, bus.buf_prin);
    end
    bus.seal = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      tests_run++;
      if (bus.buf_prin !== 5'd4) begin tests_failed++; $display("[TB] FAIL seal_step%0d: got prin %0d want 4", i, bus.buf_prin); end
    end
    bus.seal = 1'b0;
    repeat (21) cycle();
    bus.enable = 1'b0; bus.seal = 1'b1;
    repeat (27) cycle();
    bus.seal = 1'b0;
    tests_run++;
    if (bus.buf_prin !== 5'd0 || bus.ro !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL seal_empty: got prin %0d ro %b want 0 1", bus.buf_prin, bus.ro);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 14'h3FFF;
      tests_run++;
      if (o !== e) begin tests_failed++; $display("[TB] FAIL seal_sb: got k%0d p%0d s%0d want k%0d p%0d s%0d", o[13:12], o[11:7], o[6:0], e[13:12], e[11:7], e[6:0]); end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL seal_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e, o;
    bus.op_qty = 7'd3; bus.op_req = 1'b1;
    cycle();
    bus.op_req = 1'b0;
    cycle();
    bus.op_qty = 7'd7; bus.op_req = 1'b1;
    exp_q.push_back({2'd2, 5'd0, 7'd59});
    cycle();
    bus.op_req = 1'b0;
    cycle();
    bus.enable = 1'b1;
    exp_q.push_back({2'd3, 5'd20, 7'd39});
    exp_q.push_back({2'd1, 5'd20, 7'd42});
    repeat (25) cycle();
    tests_run++;
    if (bus.estado !== 2'b00 || bus.buf_sec !== 7'd42) begin
      tests_failed++; $display("[TB] FAIL b2b_end: got estado %b sec %0d want 00 42", bus.estado, bus.buf_sec);
    end
    bus.op_qty = 7'd0; bus.op_req = 1'b1;
    exp_q.push_back({2'd1, 5'd20, 7'd42});
    cycle();
    bus.op_req = 1'b0;
    cycle();
    tests_run++;
    if (bus.estado !== 2'b00 || bus.op_ack !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL zero_qty: got estado %b ack %b want 00 1", bus.estado, bus.op_ack);
    end
    cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 14'h3FFF;
      tests_run++;
      if (o !== e) begin tests_failed++; $display("[TB] FAIL b2b_sb: got k%0d p%0d s%0d want k%0d p%0d s%0d", o[13:12], o[11:7], o[6:0], e[13:12], e[11:7], e[6:0]); end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL b2b_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_pause_and_clear();
    logic [13:0] e, o;
    bus.op_qty = 7'd8; bus.op_req = 1'b1;
    exp_q.push_back({2'd1, 5'd20, 7'd50});
    cycle();
    bus.op_req = 1'b0;
    cycle();
    repeat (3) cycle();
    bus.enable = 1'b0;
    repeat (5) cycle();
    tests_run++;
    if (bus.estado !== 2'b10 || bus.buf_sec !== 7'd45) begin
      tests_failed++; $display("[TB] FAIL pause_hold: got estado %b sec %0d want 10 45", bus.estado, bus.buf_sec);
    end
    bus.enable = 1'b1;
    repeat (5) cycle();
    tests_run++;
    if (bus.estado !== 2'b00 || bus.buf_sec !== 7'd50) begin
      tests_failed++; $display("[TB] FAIL pause_end: got estado %b sec %0d want 00 50", bus.estado, bus.buf_sec);
    end
    bus.enable = 1'b0; bus.seal = 1'b1;
    repeat (16) cycle();
    bus.seal = 1'b0; bus.enable = 1'b1;
    repeat (6) cycle();
    tests_run++;
    if (bus.estado !== 2'b01 || bus.buf_prin !== 5'd9) begin
      tests_failed++; $display("[TB] FAIL clr_setup: got estado %b prin %0d want 01 9", bus.estado, bus.buf_prin);
    end
    clr = 1'b0;
    #1;
    tests_run++;
    if (bus.estado !== 2'b00 || bus.buf_prin !== 5'd0 || bus.buf_sec !== 7'd20 || bus.ro !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL clr_mid_refill: got estado %b prin %0d sec %0d ro %b want 00 0 20 1", bus.estado, bus.buf_prin, bus.buf_sec, bus.ro);
    end
    bus.enable = 1'b0;
    repeat (2) cycle();
    clr = 1'b1;
    repeat (2) cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 14'h3FFF;
      tests_run++;
      if (o !== e) begin tests_failed++; $display("[TB] FAIL pause_sb: got k%0d p%0d s%0d want k%0d p%0d s%0d", o[13:12], o[11:7], o[6:0], e[13:12], e[11:7], e[6:0]); end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL clr_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_refill_priority();
    test_capacity();
    test_seal();
    test_back_to_back();
    test_pause_and_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
